// File: rtl/ihc_apb_mailbox.sv
// APB3 inter-hart mailbox: TX FIFO is filled over APB and drained by the fabric; RX FIFO is filled by the fabric and read over APB.
// Define IHC_MBOX_IRQ_EN to add the IRQ output and the IRQ_EN register at offset 0x0C.
module ihc_apb_mailbox #(
    parameter int APB_DWIDTH = 32,
    parameter int ADDR_BITS  = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_BITS-1:0]  PADDR,
    input  logic [APB_DWIDTH-1:0] PWDATA,
    output logic [APB_DWIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [APB_DWIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    input  logic [APB_DWIDTH-1:0] RX_DATA,
    input  logic                  RX_VALID,
    output logic                  RX_READY
`ifdef IHC_MBOX_IRQ_EN
    ,
    output logic                  IRQ
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PW:0]           r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [APB_DWIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [APB_DWIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic                  r_wait;
    logic                  r_err;
    logic [APB_DWIDTH-1:0] r_prdata;

    logic [ADDR_BITS-1:0]  w_offset;
    logic                  w_sel_tx, w_sel_rx, w_sel_st, w_sel_irq;
    logic                  w_access, w_first, w_done;
    logic [PW:0]           w_tx_count, w_rx_count;
    logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_tx_ovf;
    logic [APB_DWIDTH-1:0] w_status, w_rd_data;
    logic                  w_rd_err;
`ifdef IHC_MBOX_IRQ_EN
    logic [1:0]            r_irq_en;
    logic                  r_irq;
`endif

    assign w_offset = PADDR & ~ADDR_BITS'(3);
    assign w_sel_tx = (w_offset == ADDR_BITS'(0));
    assign w_sel_rx = (w_offset == ADDR_BITS'(4));
    assign w_sel_st = (w_offset == ADDR_BITS'(8));
`ifdef IHC_MBOX_IRQ_EN
    assign w_sel_irq = (w_offset == ADDR_BITS'(12));
`else
    assign w_sel_irq = 1'b0;
`endif

    // First access cycle raises the wait flag; the second completes the transfer.
    assign w_access = PSEL & PENABLE;
    assign w_first  = w_access & ~r_wait;
    assign w_done   = w_access & r_wait;

    assign w_tx_count = r_tx_wr - r_tx_rd;
    assign w_rx_count = r_rx_wr - r_rx_rd;
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_tx_full  = (r_tx_wr[PW] != r_tx_rd[PW]) && (r_tx_wr[PW-1:0] == r_tx_rd[PW-1:0]);
    assign w_rx_full  = (r_rx_wr[PW] != r_rx_rd[PW]) && (r_rx_wr[PW-1:0] == r_rx_rd[PW-1:0]);

    assign w_status = {8'h00, 8'(w_rx_count), 8'(w_tx_count), 4'h0,
                       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    assign TX_VALID  = ~w_tx_empty;
    assign TX_DATA   = r_tx_mem[r_tx_rd[PW-1:0]];
    assign RX_READY  = ~w_rx_full;
    assign w_tx_pop  = TX_VALID & TX_READY;
    assign w_rx_push = RX_VALID & RX_READY;

    // A TX push at full is legal only when the fabric frees a slot on the same edge.
    assign w_tx_ovf  = PWRITE & w_sel_tx & w_tx_full & ~w_tx_pop;
    assign w_tx_push = w_done & PWRITE & w_sel_tx & ~r_err & ~w_tx_ovf;
    assign w_rx_pop  = w_done & ~PWRITE & w_sel_rx & ~r_err;

    assign PREADY  = w_done;
    assign PSLVERR = w_done & (r_err | w_tx_ovf);
    assign PRDATA  = w_done ? r_prdata : '0;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (PWRITE) begin
            w_rd_err = ~(w_sel_tx | w_sel_rx | w_sel_st | w_sel_irq);
        end else if (w_sel_rx) begin
            if (w_rx_empty) w_rd_err = 1'b1;
            else            w_rd_data = r_rx_mem[r_rx_rd[PW-1:0]];
        end else if (w_sel_st) begin
            w_rd_data = w_status;
`ifdef IHC_MBOX_IRQ_EN
        end else if (w_sel_irq) begin
            w_rd_data = APB_DWIDTH'(r_irq_en);
`endif
        end else begin
            w_rd_err = 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_wait   <= 1'b0;
            r_err    <= 1'b0;
            r_prdata <= '0;
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
        end else begin
            r_wait <= w_first;
            if (w_first) begin
                r_prdata <= w_rd_data;
                r_err    <= w_rd_err;
            end
            if (w_tx_push) r_tx_wr <= r_tx_wr + (PW+1)'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + (PW+1)'(1);
            if (w_rx_push) r_rx_wr <= r_rx_wr + (PW+1)'(1);
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + (PW+1)'(1);
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge PCLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[PW-1:0]] <= PWDATA;
        if (w_rx_push) r_rx_mem[r_rx_wr[PW-1:0]] <= RX_DATA;
    end

`ifdef IHC_MBOX_IRQ_EN
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_irq_en <= 2'b00;
            r_irq    <= 1'b0;
        end else begin
            if (w_done & PWRITE & w_sel_irq) r_irq_en <= PWDATA[1:0];
            r_irq <= (r_irq_en[0] & ~w_rx_empty) | (r_irq_en[1] & w_tx_empty);
        end
    end

    assign IRQ = r_irq;
`endif
endmodule

// File: tb/tb_ihc_apb_mailbox.sv
// Self-checking bench for ihc_apb_mailbox: directed scenarios then randomized APB/fabric traffic against a queue-based model.
module tb_ihc_apb_mailbox;
    localparam int DEPTH = 8;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] TX_DATA, RX_DATA;
    logic        TX_VALID, TX_READY, RX_VALID, RX_READY;
`ifdef IHC_MBOX_IRQ_EN
    logic        IRQ;
`endif

    ihc_apb_mailbox #(.APB_DWIDTH(32), .ADDR_BITS(12), .FIFO_DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY)
`ifdef IHC_MBOX_IRQ_EN
        , .IRQ(IRQ)
`endif
    );

    always #5 PCLK = ~PCLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [1:0]  m_irq_en;
    logic        m_irq;
    int          pend_kind;   // APB effect on the coming edge: 0 none, 1 TX push, 2 RX pop, 3 IRQ_EN write
    logic [31:0] pend_data;
    bit          rand_fabric;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_model();
        int t;
        int r;
        t = tx_q.size();
        r = rx_q.size();
        return 32'(int'(t == DEPTH) + 2 * int'(t == 0) + 4 * int'(r == DEPTH) + 8 * int'(r == 0)
                   + 256 * t + 65536 * r);
    endfunction

    // Drive fabric inputs for this cycle, let outputs settle, check the fabric side.
    task automatic pre();
        if (rand_fabric) begin
            TX_READY = ($urandom_range(0, 2) == 0);
            RX_VALID = ($urandom_range(0, 1) == 1);
            RX_DATA  = $urandom();
        end
        #1;
        check("tx_valid", 32'(TX_VALID), 32'(tx_q.size() != 0));
        if (tx_q.size() != 0) check("tx_data", TX_DATA, tx_q[0]);
        check("rx_ready", 32'(RX_READY), 32'(rx_q.size() < DEPTH));
`ifdef IHC_MBOX_IRQ_EN
        check("irq", 32'(IRQ), 32'(m_irq));
`endif
    endtask

    // Advance one clock and apply every handshake that completes on that edge to the model.
    task automatic post();
        bit          tx_pop;
        bit          rx_push;
        bit          irq_next;
        logic [31:0] rx_word;
        tx_pop   = TX_READY && (tx_q.size() != 0);
        rx_push  = RX_VALID && (rx_q.size() < DEPTH);
        irq_next = (m_irq_en[0] && rx_q.size() != 0) || (m_irq_en[1] && tx_q.size() == 0);
        rx_word  = RX_DATA;
        @(posedge PCLK);
        if (tx_pop)         void'(tx_q.pop_front());
        if (pend_kind == 1) tx_q.push_back(pend_data);
        if (pend_kind == 2) void'(rx_q.pop_front());
        if (pend_kind == 3) m_irq_en = pend_data[1:0];
        if (rx_push)        rx_q.push_back(rx_word);
        m_irq     = irq_next;
        pend_kind = 0;
        @(negedge PCLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pre();
            post();
        end
    endtask

    task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          kind;
        logic [9:0]  word;
        word = addr[11:2];
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        pre();
        check($sformatf("setup_pready@%h", addr), 32'(PREADY), 0);
        check($sformatf("setup_prdata@%h", addr), PRDATA, 0);
        post();
        PENABLE = 1'b1;
        pre();
        check($sformatf("wait_pready@%h", addr), 32'(PREADY), 0);
        check($sformatf("wait_pslverr@%h", addr), 32'(PSLVERR), 0);
        exp_rd = 32'h0; exp_err = 1'b0; kind = 0;
        case (word)
            10'd0: if (wr) kind = 1; else exp_err = 1'b1;
            10'd1: if (!wr) begin
                       if (rx_q.size() == 0) exp_err = 1'b1;
                       else begin exp_rd = rx_q[0]; kind = 2; end
                   end
            10'd2: if (!wr) exp_rd = status_model();
`ifdef IHC_MBOX_IRQ_EN
            10'd3: if (wr) kind = 3; else exp_rd = 32'(m_irq_en);
`endif
            default: exp_err = 1'b1;
        endcase
        post();
        pre();
        if (kind == 1 && tx_q.size() == DEPTH && !TX_READY) begin
            exp_err = 1'b1;
            kind    = 0;
        end
        check($sformatf("pready@%h", addr), 32'(PREADY), 1);
        check($sformatf("pslverr@%h", addr), 32'(PSLVERR), 32'(exp_err));
        check($sformatf("prdata@%h", addr), PRDATA, exp_rd);
        pend_kind = kind;
        pend_data = wdata;
        post();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Access abandoned after the first access cycle: must leave no trace.
    task automatic apb_abort(input logic [11:0] addr, input logic [31:0] wdata);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = wdata;
        pre();
        post();
        PENABLE = 1'b1;
        pre();
        check("abort_wait_pready", 32'(PREADY), 0);
        post();
        PSEL = 1'b0; PENABLE = 1'b0;
        pre();
        check("abort_pready", 32'(PREADY), 0);
        check("abort_pslverr", 32'(PSLVERR), 0);
        post();
    endtask

    initial begin
        logic [11:0] addr;
        logic [1:0]  lo;
        PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        TX_READY = 1'b0; RX_VALID = 1'b0; RX_DATA = '0;
        m_irq = 1'b0; m_irq_en = 2'b00; pend_kind = 0; pend_data = '0; rand_fabric = 1'b0;

        // Reset values, then STATUS after reset.
        #2;
        check("rst_pready", 32'(PREADY), 0);
        check("rst_pslverr", 32'(PSLVERR), 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_tx_valid", 32'(TX_VALID), 0);
        check("rst_rx_ready", 32'(RX_READY), 1);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETN = 1'b1;
        apb(1'b0, 12'h008, '0);

        // Two TX writes held by the fabric, then drained in order.
        apb(1'b1, 12'h000, 32'h11);
        apb(1'b1, 12'h000, 32'h22);
        apb(1'b0, 12'h008, '0);
        TX_READY = 1'b1;
        idle(2);
        TX_READY = 1'b0;
        idle(1);

        // Nine writes into an eight-deep TX FIFO; byte address bits ignored on the last.
        for (int i = 0; i < 8; i++) apb(1'b1, 12'h000, 32'h100 + 32'(i));
        apb(1'b1, 12'h003, 32'h1FF);
        apb(1'b0, 12'h008, '0);
        TX_READY = 1'b1;
        idle(DEPTH + 1);
        TX_READY = 1'b0;

        // Illegal and ignored accesses.
        apb(1'b0, 12'h000, '0);
        apb(1'b0, 12'h010, '0);
        apb(1'b1, 12'h010, 32'hDEAD);
        apb(1'b1, 12'h008, 32'hFFFF_FFFF);
        apb(1'b1, 12'h004, 32'hFFFF_FFFF);
        apb(1'b0, 12'h00C, '0);

        // RX empty read, then one fabric message.
        apb(1'b0, 12'h004, '0);
        RX_VALID = 1'b1; RX_DATA = 32'hCAFE_0001;
        idle(1);
        RX_VALID = 1'b0;
        apb(1'b0, 12'h004, '0);
        apb(1'b0, 12'h008, '0);

        // Fill RX, hold a pending message while full, pop once so it lands, then drain in order.
        RX_VALID = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            RX_DATA = 32'hA000_0000 + 32'(i);
            idle(1);
        end
        RX_DATA = 32'hA000_00FF;
        idle(1);
        apb(1'b0, 12'h004, '0);
        idle(1);
        RX_VALID = 1'b0;
        apb(1'b0, 12'h008, '0);
        for (int i = 0; i < DEPTH; i++) apb(1'b0, 12'h004, '0);

        // Abandoned access, followed by a normal one.
        apb_abort(12'h000, 32'h5555);
        apb(1'b0, 12'h008, '0);

`ifdef IHC_MBOX_IRQ_EN
        apb(1'b1, 12'h00C, 32'h1);
        apb(1'b0, 12'h00C, '0);
        RX_VALID = 1'b1; RX_DATA = 32'h1234_5678;
        idle(1);
        RX_VALID = 1'b0;
        idle(2);
        apb(1'b0, 12'h004, '0);
        idle(2);
        apb(1'b1, 12'h00C, 32'h2);
        idle(2);
        apb(1'b1, 12'h00C, 32'h0);
`endif

        // Randomized traffic with a randomly behaving fabric.
        rand_fabric = 1'b1;
        for (int n = 0; n < 400; n++) begin
            lo = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0, 1: apb(1'b1, {10'd0, lo}, $urandom());
                2, 3: apb(1'b0, {10'd1, lo}, '0);
                4:    apb(1'b0, {10'd2, lo}, '0);
                5: begin
                    addr = 12'($urandom_range(0, 4095));
                    apb(1'($urandom_range(0, 1)), addr, $urandom());
                end
                6:    apb_abort({10'd0, lo}, $urandom());
                default: apb(1'($urandom_range(0, 1)), 12'h00C, 32'($urandom_range(0, 3)));
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_fabric = 1'b0;
        TX_READY = 1'b0; RX_VALID = 1'b0;
        idle(1);

        // Reset during access cycle 1 of a TXDATA write.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'hBAD0_0001;
        pre();
        post();
        PENABLE = 1'b1;
        #1;
        PRESETN = 1'b0;
        #1;
        check("midrst_pready", 32'(PREADY), 0);
        check("midrst_pslverr", 32'(PSLVERR), 0);
        check("midrst_prdata", PRDATA, 0);
        check("midrst_tx_valid", 32'(TX_VALID), 0);
        check("midrst_rx_ready", 32'(RX_READY), 1);
        tx_q.delete();
        rx_q.delete();
        m_irq = 1'b0; m_irq_en = 2'b00; pend_kind = 0;
        @(posedge PCLK);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        PRESETN = 1'b1;
        idle(1);
        apb(1'b0, 12'h008, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
